synaptic_current_integrator: RTL and testbench
==============================================

# synaptic_current_integrator

Upstream stage of the Izhikevich neuron core. It accepts weighted spike events from presynaptic sources and accumulates them into a synaptic current state. Once per simulation timestep it applies exponential decay and adds a bias. It then presents the resulting 18-bit signed current on `i` and pulses `apply` for one cycle, which drives the core's `i` and `apply` inputs directly. All values use the core's fixed-point format: Q2.16, two's complement, 1.0 = 18'sh1_0000.

## Interface
- `N`, 18: data width (Q2.16).
- `NUM_SYN`, 8: number of synapses (weight table depth).
- `IDX_W`, `$clog2(NUM_SYN)`: synapse index width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `event_valid` in 1: spike event offered.
- `event_syn` in `IDX_W`: synapse index of the event.
- `event_ready` out 1: block accepts an event this cycle.
- `tick` in 1: one-cycle pulse that closes the current timestep.
- `tau_shift` in 4: decay shift amount; decay factor is 1 - 2^-tau_shift.
- `i_bias` in N: constant current added to the output.
- `wr_en` in 1: weight table write strobe.
- `wr_addr` in `IDX_W`: weight table write address.
- `wr_data` in N: signed weight to write.
- `i` out N: current to the neuron core; held between updates.
- `apply` out 1: one-cycle strobe; `i` is valid this cycle.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `tick_overrun` out 1: sticky; a tick arrived while busy.

## Operation
- FSM states: IDLE → DECAY → APPLY → IDLE.
  - IDLE → DECAY on `tick`.
  - DECAY and APPLY each last exactly one cycle.
- Accumulation:
  - `event_ready` = (state == IDLE); it is driven combinationally from state.
  - An accepted event (`event_valid & event_ready`) adds `weight[event_syn]` to `acc` in that cycle.
  - An event accepted in the same cycle as `tick` is included in this timestep.
- DECAY:
  - `acc <= acc - (acc >>> tau_shift)`, using an arithmetic shift.
  - `i <= decayed + i_bias`.
  - `tau_shift` = 0 clears `acc` to 0, so `i` = `i_bias`.
  - `tau_shift` values 0 to 15 are all legal.
- APPLY: `apply` = 1 for one cycle; `i` is stable from this cycle until the next APPLY.
- Weight table:
  - `NUM_SYN` x N-bit registers.
  - A write takes effect on the next cycle.
  - A write and an event targeting the same index in the same cycle: the event uses the old weight.
  - Writes are legal in any state.
- Tick while busy:
  - The tick is ignored and `tick_overrun` is set.
  - The in-flight update completes normally.
  - `tick_overrun` clears only on `reset`.
- Arithmetic: the `acc` add, the decay subtract and the bias add are each N-bit, with overflow handled per Configuration.
- Reset values: `acc`=0, `i`=0, `apply`=0, every weight=0, `tick_overrun`=0, state=IDLE. After reset, `event_ready`=1 and `busy`=0.
- Reset mid-operation (in DECAY or APPLY): `apply` never asserts for the aborted step. All state returns to its reset values on the next edge.

## Timing
- `tick` at cycle T → DECAY at T+1 → `i` updated and `apply` high at T+2. Latency is 2 cycles.
- `event_ready` is low during T+1 and T+2. Events offered then are held off by valid/ready; the source must keep `event_valid` and `event_syn` stable until accepted.
- Minimum tick spacing is 3 cycles.
- One event is accepted per cycle at most; throughput is 1 event/cycle in IDLE.

## Configuration
- Macro: `SYN_SATURATE_EN`.
- Defined: every add and subtract saturates to 18'sh1_FFFF (max) or 18'sh2_0000 (min).
- Undefined: every add and subtract wraps modulo 2^N. Saturation logic is absent.

## Structure
- Package `snn_fixed_pkg` holds:
  - `N`;
  - the Q2.16 constants `FX_ONE`, `FX_MAX`, `FX_MIN`;
  - the typedef `fx_t` (logic signed [N-1:0]);
  - the FSM enum `syn_state_t`.
- Sub-module `fx_add_sat`: signed N-bit add with a subtract flag. It is conditionally saturating under `SYN_SATURATE_EN` and is instantiated three times (accumulate, decay, bias).

## Test plan
- Decay: weight[0]=18'sh0_2666 (0.15), one event on syn 0, `tick`, `tau_shift`=2, `i_bias`=0 → `apply` at T+2 with `i`=18'sh0_1CCD; `acc`=18'sh0_1CCD.
- Overflow:
  - weight[1]=18'sh1_0000; accept 3 events, then `tick` with `tau_shift`=15.
  - With `SYN_SATURATE_EN`: `acc` clamps to 18'sh1_FFFF at the second event, and `i`=18'sh1_FFFF − 18'sh0_0003 = 18'sh1_FFFC.
  - Without it: `acc`=18'sh3_0000 (−1.0) after three events, and `i`=18'sh3_0000 + 18'sh0_0002 = 18'sh3_0002.
- Handshake: hold `event_valid`=1 across a `tick` → `event_ready` is low for 2 cycles, the event is accepted in the first cycle back in IDLE, and it contributes to the next timestep only.
- Tick overrun: a second `tick` at T+1 → `tick_overrun`=1 and exactly one `apply` pulse; `tick_overrun` stays 1 until `reset`.
- Full decay and bias: `tau_shift`=0, `i_bias`=18'sh0_2666, any `acc` → `i`=18'sh0_2666 and `acc`=0.
- Reset mid-step: assert `reset` in DECAY → no `apply`; next cycle `i`=0, `event_ready`=1, all weights read 0.

Source files
------------

// File: rtl/snn_fixed_pkg.sv
// rtl/snn_fixed_pkg.sv - Q2.16 fixed-point types, constants and integrator FSM states
package snn_fixed_pkg;

    localparam int N = 18;

    typedef logic signed [N-1:0] fx_t;

    localparam fx_t FX_ONE = 18'sh1_0000;
    localparam fx_t FX_MAX = 18'sh1_FFFF;
    localparam fx_t FX_MIN = 18'sh2_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DECAY = 2'd1,
        ST_APPLY = 2'd2
    } syn_state_t;

endpackage

// File: rtl/fx_add_sat.sv
// rtl/fx_add_sat.sv - signed Q2.16 add/subtract; saturates when SYN_SATURATE_EN is defined, wraps otherwise
module fx_add_sat
    import snn_fixed_pkg::*;
(
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    input  logic                sub,
    output logic signed [N-1:0] y
);

`ifdef SYN_SATURATE_EN
    logic [N:0] b_ext;
    logic [N:0] sum;

    // One guard bit is enough: two N-bit operands can never overflow N+1 bits.
    always_comb begin
        b_ext = sub ? -{b[N-1], b} : {b[N-1], b};
        sum   = {a[N-1], a} + b_ext;
        if (sum[N] != sum[N-1]) begin
            y = sum[N] ? FX_MIN : FX_MAX;
        end else begin
            y = sum[N-1:0];
        end
    end
`else
    assign y = sub ? (a - b) : (a + b);
`endif

endmodule

// File: rtl/synaptic_current_integrator.sv
// rtl/synaptic_current_integrator.sv - accumulates weighted spikes, decays and biases once per tick (SYN_SATURATE_EN selects saturation)
module synaptic_current_integrator
    import snn_fixed_pkg::*;
#(
    parameter int NUM_SYN = 8,
    parameter int IDX_W   = $clog2(NUM_SYN)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                event_valid,
    input  logic [IDX_W-1:0]    event_syn,
    output logic                event_ready,
    input  logic                tick,
    input  logic [3:0]          tau_shift,
    input  logic signed [N-1:0] i_bias,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic signed [N-1:0] wr_data,
    output logic signed [N-1:0] i,
    output logic                apply,
    output logic                busy,
    output logic                tick_overrun
);

    syn_state_t state;
    syn_state_t state_next;

    fx_t acc;
    fx_t weight [NUM_SYN];
    fx_t acc_sum;
    fx_t acc_shifted;
    fx_t decayed;
    fx_t biased;
    logic event_fire;

    assign event_ready = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign event_fire  = event_valid & event_ready;
    // Reset gates the strobe so an aborted step never presents a partial result.
    assign apply       = (state == ST_APPLY) & ~reset;
    assign acc_shifted = acc >>> tau_shift;

    fx_add_sat u_acc_add (
        .a   (acc),
        .b   (weight[event_syn]),
        .sub (1'b0),
        .y   (acc_sum)
    );

    fx_add_sat u_decay_sub (
        .a   (acc),
        .b   (acc_shifted),
        .sub (1'b1),
        .y   (decayed)
    );

    fx_add_sat u_bias_add (
        .a   (decayed),
        .b   (i_bias),
        .sub (1'b0),
        .y   (biased)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (tick) state_next = ST_DECAY;
            ST_DECAY: state_next = ST_APPLY;
            ST_APPLY: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Accumulation only happens in IDLE and decay only in DECAY, so the acc updates never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc          <= '0;
            i            <= '0;
            tick_overrun <= 1'b0;
            for (int k = 0; k < NUM_SYN; k++) begin
                weight[k] <= '0;
            end
        end else begin
            if (wr_en) begin
                weight[wr_addr] <= wr_data;
            end
            if (event_fire) begin
                acc <= acc_sum;
            end
            if (state == ST_DECAY) begin
                acc <= decayed;
                i   <= biased;
            end
            if (tick && busy) begin
                tick_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_synaptic_current_integrator.sv
// tb/tb_synaptic_current_integrator.sv - directed vector bench for synaptic_current_integrator (honours SYN_SATURATE_EN)
module tb_synaptic_current_integrator;

    logic        clk = 1'b0;
    logic        reset;
    logic        event_valid;
    logic [2:0]  event_syn;
    logic        event_ready;
    logic        tick;
    logic [3:0]  tau_shift;
    logic signed [17:0] i_bias;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic signed [17:0] wr_data;
    logic signed [17:0] i;
    logic        apply;
    logic        busy;
    logic        tick_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    synaptic_current_integrator dut (
        .clk          (clk),
        .reset        (reset),
        .event_valid  (event_valid),
        .event_syn    (event_syn),
        .event_ready  (event_ready),
        .tick         (tick),
        .tau_shift    (tau_shift),
        .i_bias       (i_bias),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .i            (i),
        .apply        (apply),
        .busy         (busy),
        .tick_overrun (tick_overrun)
    );

    typedef struct {
        logic [2:0]  syn;
        logic [17:0] w;
        int          n;
        logic [3:0]  tau;
        logic [17:0] bias;
        logic [17:0] exp_i;
        logic [17:0] exp_acc;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        event_valid = 1'b0;
        tick        = 1'b0;
        wr_en       = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic write_weight(input logic [2:0] addr, input logic [17:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic tick_and_wait(output int lat);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        lat  = 0;
        while (!apply && lat < 8) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int lat;
        int napply;
        logic saw_apply;

        reset       = 1'b1;
        event_valid = 1'b0;
        event_syn   = '0;
        tick        = 1'b0;
        tau_shift   = '0;
        i_bias      = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;

        vecs[0] = '{syn: 3'd0, w: 18'h02666, n: 1, tau: 4'd2,  bias: 18'h00000, exp_i: 18'h01CCD, exp_acc: 18'h01CCD};
`ifdef SYN_SATURATE_EN
        vecs[1] = '{syn: 3'd1, w: 18'h10000, n: 3, tau: 4'd15, bias: 18'h00000, exp_i: 18'h1FFFC, exp_acc: 18'h1FFFC};
        vecs[6] = '{syn: 3'd7, w: 18'h18000, n: 1, tau: 4'd15, bias: 18'h10000, exp_i: 18'h1FFFF, exp_acc: 18'h17FFD};
`else
        vecs[1] = '{syn: 3'd1, w: 18'h10000, n: 3, tau: 4'd15, bias: 18'h00000, exp_i: 18'h30002, exp_acc: 18'h30002};
        vecs[6] = '{syn: 3'd7, w: 18'h18000, n: 1, tau: 4'd15, bias: 18'h10000, exp_i: 18'h27FFD, exp_acc: 18'h17FFD};
`endif
        vecs[2] = '{syn: 3'd5, w: 18'h08000, n: 2, tau: 4'd0,  bias: 18'h02666, exp_i: 18'h02666, exp_acc: 18'h00000};
        vecs[3] = '{syn: 3'd6, w: 18'h38000, n: 1, tau: 4'd1,  bias: 18'h01000, exp_i: 18'h3D000, exp_acc: 18'h3C000};
        vecs[4] = '{syn: 3'd2, w: 18'h01234, n: 0, tau: 4'd4,  bias: 18'h3FFFF, exp_i: 18'h3FFFF, exp_acc: 18'h00000};
        vecs[5] = '{syn: 3'd4, w: 18'h00100, n: 4, tau: 4'd3,  bias: 18'h00010, exp_i: 18'h00390, exp_acc: 18'h00380};

        // Reset state
        do_reset();
        check("rst_event_ready", {17'b0, event_ready}, 18'd1);
        check("rst_busy", {17'b0, busy}, 18'd0);
        check("rst_apply", {17'b0, apply}, 18'd0);
        check("rst_i", i, 18'h0);
        check("rst_overrun", {17'b0, tick_overrun}, 18'd0);
        check("rst_acc", dut.acc, 18'h0);

        // Single-timestep vectors
        for (int v = 0; v < 7; v++) begin
            do_reset();
            write_weight(vecs[v].syn, vecs[v].w);
            for (int k = 0; k < vecs[v].n; k++) begin
                event_valid = 1'b1;
                event_syn   = vecs[v].syn;
                @(negedge clk);
            end
            event_valid = 1'b0;
            tau_shift   = vecs[v].tau;
            i_bias      = vecs[v].bias;
            tick_and_wait(lat);
            check($sformatf("v%0d_latency", v), 18'(lat), 18'd1);
            check($sformatf("v%0d_apply", v), {17'b0, apply}, 18'd1);
            check($sformatf("v%0d_i", v), i, vecs[v].exp_i);
            check($sformatf("v%0d_acc", v), dut.acc, vecs[v].exp_acc);
            @(negedge clk);
            check($sformatf("v%0d_apply_drop", v), {17'b0, apply}, 18'd0);
            check($sformatf("v%0d_i_hold", v), i, vecs[v].exp_i);
        end

        // Handshake: event offered while busy waits for IDLE, lands in the next timestep
        do_reset();
        write_weight(3'd2, 18'h00100);
        tau_shift = 4'd15;
        i_bias    = 18'h0;
        tick = 1'b1;
        @(negedge clk);
        tick        = 1'b0;
        event_valid = 1'b1;
        event_syn   = 3'd2;
        check("hs_ready_decay", {17'b0, event_ready}, 18'd0);
        @(negedge clk);
        check("hs_ready_apply", {17'b0, event_ready}, 18'd0);
        check("hs_apply", {17'b0, apply}, 18'd1);
        check("hs_i_excl", i, 18'h0);
        @(negedge clk);
        check("hs_ready_idle", {17'b0, event_ready}, 18'd1);
        check("hs_acc_before", dut.acc, 18'h0);
        @(negedge clk);
        event_valid = 1'b0;
        check("hs_acc_after", dut.acc, 18'h00100);
        tick_and_wait(lat);
        check("hs_next_i", i, 18'h00100);
        @(negedge clk);
        // Event in the same cycle as tick belongs to that timestep
        event_valid = 1'b1;
        event_syn   = 3'd2;
        tick        = 1'b1;
        @(negedge clk);
        event_valid = 1'b0;
        tick        = 1'b0;
        @(negedge clk);
        check("same_cycle_apply", {17'b0, apply}, 18'd1);
        check("same_cycle_i", i, 18'h00200);

        // Write and event to the same index in one cycle: event sees the old weight
        do_reset();
        write_weight(3'd3, 18'h00100);
        wr_en       = 1'b1;
        wr_addr     = 3'd3;
        wr_data     = 18'h00200;
        event_valid = 1'b1;
        event_syn   = 3'd3;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        event_valid = 1'b0;
        check("wr_old_then_new", dut.acc, 18'h00300);

        // Tick overrun
        do_reset();
        napply = 0;
        tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tick = 1'b0;
        check("ovr_set", {17'b0, tick_overrun}, 18'd1);
        napply += int'(apply);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            napply += int'(apply);
        end
        check("ovr_one_apply", 18'(napply), 18'd1);
        check("ovr_sticky", {17'b0, tick_overrun}, 18'd1);
        check("ovr_idle", {17'b0, busy}, 18'd0);
        do_reset();
        check("ovr_cleared", {17'b0, tick_overrun}, 18'd0);

        // Reset during DECAY
        do_reset();
        write_weight(3'd5, 18'h01234);
        event_valid = 1'b1;
        event_syn   = 3'd5;
        @(negedge clk);
        event_valid = 1'b0;
        tau_shift   = 4'd1;
        i_bias      = 18'h00100;
        tick_and_wait(lat);
        check("mid_prev_i", i, 18'h00A1A);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick      = 1'b0;
        reset     = 1'b1;
        saw_apply = apply;
        @(negedge clk);
        reset = 1'b0;
        saw_apply = saw_apply | apply;
        check("mid_i", i, 18'h0);
        check("mid_ready", {17'b0, event_ready}, 18'd1);
        check("mid_busy", {17'b0, busy}, 18'd0);
        check("mid_acc", dut.acc, 18'h0);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("mid_weight%0d", k), dut.weight[k], 18'h0);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            saw_apply = saw_apply | apply;
        end
        check("mid_no_apply", {17'b0, saw_apply}, 18'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
